duoji_dispense_ctrl: RTL
========================

// Module: duoji_dispense_ctrl
// PURPOSE
// - Downstream of the payment/price calculator: consumes its en_duoji level and performs one dispense cycle per
//   rising edge of en_duoji.
// - Drives the hobby servo (duoji) with 50 Hz PWM: close -> open -> hold -> close; reports busy/done.
// - Re-arms only after en_duoji has been seen low, so a latched-high enable cannot dispense twice.
// PARAMETERS
// - PWM_PERIOD_CYC   1_000_000  clock cycles per PWM frame (20 ms @ 50 MHz)
// - PULSE_CLOSE_CYC  50_000     high time for closed position (1.0 ms)
// - PULSE_OPEN_CYC   100_000    high time for open position (2.0 ms)
// - HOLD_FRAMES      50         frames held at open position (1 s)
// - RAMP_STEP_CYC    5_000      per-frame pulse-width increment; used only with DUOJI_RAMP_EN
// PORTS
// - clock     in   1   system clock; single clock domain
// - clr       in   1   reset, synchronous, active-high
// - en_duoji  in   1   dispense request level from the calculator; rising edge starts a cycle
// - pwm_out   out  1   servo PWM
// - busy      out  1   high from the accepted request until the cycle completes
// - done      out  1   one-cycle pulse when the servo is back at the closed position
// - pos_open  out  1   high while the applied pulse width equals PULSE_OPEN_CYC
// BEHAVIOUR
// - Reset state (clr=1 at clock edge): pwm_out=0, busy=0, done=0, pos_open=0, state=IDLE, armed=0.
// - Reset state (continued): frame counter=0, applied width=PULSE_CLOSE_CYC, en_duoji edge register=0.
// - Reset mid-cycle aborts immediately. No pulse is truncated or extended except the frame cut by reset.
// - PWM: frame counter runs 0..PWM_PERIOD_CYC-1 and wraps. pwm_out registered = (cnt < width_applied).
// - PWM: first frame after reset starts at cnt=0.
// - width_applied loads only at the frame wrap (cnt==PWM_PERIOD_CYC-1 -> 0). frame_tick marks that wrap.
// - Width changes never occur mid-frame.
// - Counter width: $clog2(PWM_PERIOD_CYC). The width register has the same width.
// - Width arithmetic is unsigned and saturates at the target, with no overshoot.
// - Edge detect: req = en_duoji & ~en_q. armed sets when en_duoji==0 is sampled in IDLE.
// - A request is accepted only when armed=1.
// - FSM states:
//   - IDLE: target=CLOSE. On req&armed -> OPENING, busy=1 the next cycle, armed=0.
//   - OPENING: target=OPEN. When width_applied==PULSE_OPEN_CYC at a frame_tick -> HOLD; hold counter=0.
//   - HOLD: count frame_ticks. After HOLD_FRAMES ticks -> CLOSING.
//   - CLOSING: target=CLOSE. When width_applied==PULSE_CLOSE_CYC at a frame_tick -> IDLE.
//     The same cycle raises done=1 for one cycle and clears busy.
// - Requests arriving while busy=1 are ignored, not queued.
// - en_duoji held high through completion leaves armed=0: no second dispense until en_duoji goes low, then high.
// - Simultaneous: req and the CLOSING->IDLE transition in the same cycle -> the req is dropped, because armed=0.
// - pos_open is derived from width_applied and registered with it.
// CONFIGURATION
// - DUOJI_RAMP_EN defined: at each frame_tick, width_applied moves toward target by RAMP_STEP_CYC, clamped at target.
// - DUOJI_RAMP_EN undefined: width_applied = target at the next frame_tick (one-frame step).
//   RAMP_STEP_CYC is unused in this case.
// STRUCTURE
// - Package duoji_pkg: state enum (IDLE, OPENING, HOLD, CLOSING) and default timing localparams for 50 MHz.
// - Sub-module duoji_pwm_gen: frame counter, frame_tick, compare and registered pwm_out.
//   Its width input is sampled only at the wrap.
// - Top level holds the edge detect, arming, FSM, hold counter and ramp logic.
// TESTING (sim params: PWM_PERIOD_CYC=100, CLOSE=5, OPEN=15, HOLD_FRAMES=3, RAMP_STEP_CYC=5)
// - Reset: clr=1 for 3 cycles -> pwm_out=0, busy=0, done=0. Then every 100-cycle frame has exactly 5 high cycles.
// - Dispense without ramp: en_duoji 0->1 -> busy next cycle. Next frame high time 15.
//   Then 3 more frames at 15, next frame 5, done pulses once, busy=0.
// - Ramp (DUOJI_RAMP_EN): after req, frame highs are 10, 15, 15, 15, 15, 10, 5. pos_open is high only for the 15-frames.
// - Latched enable: en_duoji held 1 across and after completion -> no second cycle.
//   Drop to 0 for 1 cycle, raise -> second cycle runs.
// - Busy ignore: pulse en_duoji 0->1->0->1 during HOLD -> exactly one done pulse total.
// - Mid-op reset: clr=1 during HOLD -> next cycle pwm_out=0, busy=0. Subsequent frames high for 5, no done pulse.

Source files
------------

// File: rtl/duoji_pkg.sv
// Shared definitions for the servo (duoji) dispense controller.
// Contents:
//   - duoji_state_e : dispense FSM states
//   - DEF_*         : default timing for a 50 MHz clock and a 50 Hz servo frame
// Optional build macro DUOJI_RAMP_EN (used by duoji_dispense_ctrl) enables ramped width moves.
package duoji_pkg;

    localparam int unsigned DEF_PWM_PERIOD_CYC  = 32'd1_000_000; // 20 ms frame
    localparam int unsigned DEF_PULSE_CLOSE_CYC = 32'd50_000;    // 1.0 ms high = closed
    localparam int unsigned DEF_PULSE_OPEN_CYC  = 32'd100_000;   // 2.0 ms high = open
    localparam int unsigned DEF_HOLD_FRAMES     = 32'd50;        // 1 s at open
    localparam int unsigned DEF_RAMP_STEP_CYC   = 32'd5_000;     // per-frame ramp increment

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPENING = 2'd1,
        HOLD    = 2'd2,
        CLOSING = 2'd3
    } duoji_state_e;

endpackage

// File: rtl/duoji_pwm_gen.sv
// Servo PWM frame generator.
// Ports:
//   clock        : system clock
//   clr          : synchronous active-high reset
//   width_i      : requested high time, sampled only at the frame wrap
//   frame_tick_o : high in the last cycle of a frame (counter about to wrap)
//   width_o      : high time currently applied to the output
//   pwm_o        : registered PWM output, high while counter < applied width
module duoji_pwm_gen
    import duoji_pkg::*;
#(
    parameter int unsigned PWM_PERIOD_CYC  = DEF_PWM_PERIOD_CYC,
    parameter int unsigned PULSE_CLOSE_CYC = DEF_PULSE_CLOSE_CYC,
    parameter int unsigned CNT_W           = $clog2(PWM_PERIOD_CYC)
) (
    input  logic             clock,
    input  logic             clr,
    input  logic [CNT_W-1:0] width_i,
    output logic             frame_tick_o,
    output logic [CNT_W-1:0] width_o,
    output logic             pwm_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD_CYC - 32'd1);
    localparam logic [CNT_W-1:0] CLOSE_W  = CNT_W'(PULSE_CLOSE_CYC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] width_q;
    logic             pwm_q;

    assign frame_tick_o = (cnt_q == CNT_LAST);
    assign width_o      = width_q;
    assign pwm_o        = pwm_q;

    // Frame counter, width latch at the wrap (never mid-frame) and registered compare.
    always_ff @(posedge clock) begin
        if (clr) begin
            cnt_q   <= {CNT_W{1'b0}};
            width_q <= CLOSE_W;
            pwm_q   <= 1'b0;
        end else begin
            pwm_q <= (cnt_q < width_q);
            if (frame_tick_o) begin
                cnt_q   <= {CNT_W{1'b0}};
                width_q <= width_i;
            end else begin
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/duoji_dispense_ctrl.sv
// Servo dispense controller: one close -> open -> hold -> close cycle per accepted
// rising edge of en_duoji. Re-arms only after en_duoji is seen low while idle.
// Ports:
//   clock    : system clock
//   clr      : synchronous active-high reset
//   en_duoji : dispense request level; rising edge requests a cycle
//   pwm_out  : servo PWM
//   busy     : high from the accepted request until the cycle completes
//   done     : one-cycle pulse when the servo is back at the closed position
//   pos_open : high while the applied pulse width equals the open width
// Build macro: DUOJI_RAMP_EN - when defined, the width moves toward its target by
// RAMP_STEP_CYC per frame; otherwise it jumps to the target at the next frame.
module duoji_dispense_ctrl
    import duoji_pkg::*;
#(
    parameter int unsigned PWM_PERIOD_CYC  = DEF_PWM_PERIOD_CYC,
    parameter int unsigned PULSE_CLOSE_CYC = DEF_PULSE_CLOSE_CYC,
    parameter int unsigned PULSE_OPEN_CYC  = DEF_PULSE_OPEN_CYC,
    parameter int unsigned HOLD_FRAMES     = DEF_HOLD_FRAMES,
    parameter int unsigned RAMP_STEP_CYC   = DEF_RAMP_STEP_CYC
) (
    input  logic clock,
    input  logic clr,
    input  logic en_duoji,
    output logic pwm_out,
    output logic busy,
    output logic done,
    output logic pos_open
);

    localparam int unsigned CNT_W  = $clog2(PWM_PERIOD_CYC);
    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 32'd1);

    localparam logic [CNT_W-1:0]  CLOSE_W   = CNT_W'(PULSE_CLOSE_CYC);
    localparam logic [CNT_W-1:0]  OPEN_W    = CNT_W'(PULSE_OPEN_CYC);
    localparam logic [CNT_W-1:0]  STEP_W    = CNT_W'(RAMP_STEP_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 32'd1);

`ifdef DUOJI_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif

    duoji_state_e      state_q;
    logic              en_q;
    logic              armed_q;
    logic [HOLD_W-1:0] hold_q;
    logic              busy_q;
    logic              done_q;
    logic              pos_open_q;

    logic              frame_tick_s;
    logic [CNT_W-1:0]  width_applied_s;
    logic [CNT_W-1:0]  width_d;
    logic [CNT_W-1:0]  target_s;
    logic              req_s;
    logic              accept_s;
    logic              leaving_hold_s;

    // Move cur toward tgt by at most one step, landing exactly on tgt (no overshoot).
    function automatic logic [CNT_W-1:0] ramp_toward(input logic [CNT_W-1:0] cur,
                                                     input logic [CNT_W-1:0] tgt);
        logic [CNT_W-1:0] r;
        if (cur < tgt) begin
            r = ((tgt - cur) > STEP_W) ? (cur + STEP_W) : tgt;
        end else if (cur > tgt) begin
            r = ((cur - tgt) > STEP_W) ? (cur - STEP_W) : tgt;
        end else begin
            r = tgt;
        end
        return r;
    endfunction

    duoji_pwm_gen #(
        .PWM_PERIOD_CYC  (PWM_PERIOD_CYC),
        .PULSE_CLOSE_CYC (PULSE_CLOSE_CYC),
        .CNT_W           (CNT_W)
    ) u_pwm (
        .clock        (clock),
        .clr          (clr),
        .width_i      (width_d),
        .frame_tick_o (frame_tick_s),
        .width_o      (width_applied_s),
        .pwm_o        (pwm_out)
    );

    // Request decode and width target. The target follows the state being entered at
    // this frame wrap, so the frame after the last hold tick already moves toward closed.
    always_comb begin
        req_s          = en_duoji & ~en_q;
        accept_s       = (state_q == IDLE) & req_s & armed_q;
        leaving_hold_s = (state_q == HOLD) & frame_tick_s & (hold_q == HOLD_LAST);
        if (accept_s || (state_q == OPENING) || ((state_q == HOLD) && !leaving_hold_s)) begin
            target_s = OPEN_W;
        end else begin
            target_s = CLOSE_W;
        end
        if (RAMP_EN) begin
            width_d = ramp_toward(width_applied_s, target_s);
        end else begin
            width_d = target_s;
        end
    end

    // Dispense FSM with edge register, arming, hold counter and registered outputs.
    always_ff @(posedge clock) begin
        if (clr) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            armed_q    <= 1'b0;
            hold_q     <= {HOLD_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pos_open_q <= 1'b0;
        end else begin
            en_q   <= en_duoji;
            done_q <= 1'b0;
            // pos_open tracks the width register, so it updates at the same wrap.
            if (frame_tick_s) begin
                pos_open_q <= (width_d == OPEN_W);
            end
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        state_q <= OPENING;
                        busy_q  <= 1'b1;
                        armed_q <= 1'b0;
                    end else if (!en_duoji) begin
                        armed_q <= 1'b1;
                    end
                end
                OPENING: begin
                    if (frame_tick_s && (width_applied_s == OPEN_W)) begin
                        state_q <= HOLD;
                        hold_q  <= {HOLD_W{1'b0}};
                    end
                end
                HOLD: begin
                    if (frame_tick_s) begin
                        if (hold_q == HOLD_LAST) begin
                            state_q <= CLOSING;
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end
                end
                CLOSING: begin
                    if (frame_tick_s && (width_applied_s == CLOSE_W)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign pos_open = pos_open_q;

endmodule
